// File: rtl/vector_irq_ctrl_pkg.sv
// vector_irq_ctrl_pkg: handshake state encoding and vector bus width shared by the interrupt responder.
package vector_irq_ctrl_pkg;
    localparam int VEC_W = 9;
    typedef enum logic [1:0] {IDLE, LATCH, ACK, WAIT} state_e;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational priority encoder, lowest set index wins.
//   req_i  NCH request bits
//   idx_o  index of the lowest set bit (0 when none)
//   any_o  high when any request bit is set
module irq_prio_enc #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0] req_i,
    output logic [2:0]     idx_o,
    output logic           any_o
);
    always_comb begin
        idx_o = '0;
        for (int i = NCH - 1; i >= 0; i--) idx_o = req_i[i] ? 3'(i) : idx_o;
        any_o = |req_i;
    end
endmodule

// File: rtl/vector_irq_ctrl.sv
// vector_irq_ctrl: vectored-interrupt responder for one bus priority level.
//   wb_clk_i/wb_rst_i  clock, synchronous active-high reset
//   dev_irq/dev_vec    per-device request level and 9-bit vector
//   dev_iack           one-cycle acknowledge pulse to the serviced device
//   irq_o              level request to the CPU
//   istb_i             CPU vector strobe
//   vec_o/iack_o       vector bus and vector-valid acknowledge to the CPU
module vector_irq_ctrl
    import vector_irq_ctrl_pkg::*;
#(
    parameter int               NCH      = 4,
    parameter logic [VEC_W-1:0] SPUR_VEC = 9'o000
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NCH-1:0]       dev_irq,
    input  logic [NCH*VEC_W-1:0] dev_vec,
    output logic [NCH-1:0]       dev_iack,
    output logic                 irq_o,
    input  logic                 istb_i,
    output logic [VEC_W-1:0]     vec_o,
    output logic                 iack_o
);
    state_e           state_q, state_d;
    logic [NCH-1:0]   dev_irq_q, pending_q, pending_d, dev_iack_q, dev_iack_d, ack_mask;
    logic [2:0]       sel_q, sel_d, enc_idx;
    logic             spur_q, spur_d, irq_q, iack_q, iack_d, enc_any;
    logic [VEC_W-1:0] vec_q, vec_d, enc_vec;

    irq_prio_enc #(.NCH(NCH)) u_enc (.req_i(pending_q), .idx_o(enc_idx), .any_o(enc_any));

    always_comb begin
        enc_vec = '0;
        for (int i = 0; i < NCH; i++) enc_vec = (enc_idx == 3'(i)) ? dev_vec[i*VEC_W +: VEC_W] : enc_vec;
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        spur_d     = spur_q;
        vec_d      = vec_q;
        iack_d     = 1'b0;
        dev_iack_d = '0;
        ack_mask   = (state_q == LATCH && !spur_q) ? NCH'(1) << sel_q : '0;
        // withdrawal and acknowledge clear first; a fresh rising edge is ORed last so it survives
        pending_d  = (pending_q & dev_irq & ~ack_mask) | (dev_irq & ~dev_irq_q);
        case (state_q)
            IDLE: if (istb_i) begin
                state_d = LATCH;
                sel_d   = enc_idx;
                spur_d  = !enc_any;
                vec_d   = enc_any ? enc_vec : SPUR_VEC;
            end
            LATCH: begin
                state_d    = ACK;
                iack_d     = 1'b1;
                dev_iack_d = ack_mask;
            end
            ACK: state_d = WAIT;
            WAIT: if (!istb_i) begin
                state_d = IDLE;
                vec_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            dev_irq_q  <= '0;
            pending_q  <= '0;
            dev_iack_q <= '0;
            sel_q      <= '0;
            spur_q     <= 1'b0;
            irq_q      <= 1'b0;
            iack_q     <= 1'b0;
            vec_q      <= '0;
        end else begin
            state_q    <= state_d;
            dev_irq_q  <= dev_irq;
            pending_q  <= pending_d;
            dev_iack_q <= dev_iack_d;
            sel_q      <= sel_d;
            spur_q     <= spur_d;
            irq_q      <= |pending_d;
            iack_q     <= iack_d;
            vec_q      <= vec_d;
        end
    end

    assign dev_iack = dev_iack_q;
    assign irq_o    = irq_q;
    assign iack_o   = iack_q;
    assign vec_o    = vec_q;
endmodule

// File: tb/tb_vector_irq_ctrl.sv
// tb_vector_irq_ctrl: directed and randomized checks against a transaction-level reference model.
module tb_vector_irq_ctrl;
    localparam int NCH = 4;
    localparam int VW  = 9;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              istb = 1'b0;
    logic [NCH-1:0]    dev_irq = '0;
    logic [NCH*VW-1:0] dev_vec;
    logic [NCH-1:0]    dev_iack;
    logic              irq, iack;
    logic [VW-1:0]     vec;

    int checks = 0;
    int errors = 0;

    // reference model: pending set per channel, plus edges elapsed since the strobe was taken
    bit         m_pend[NCH];
    bit         m_prev[NCH];
    int         since = -1;
    int         m_sel = 0;
    bit         m_spur = 1'b0;
    logic [8:0] m_vec = '0;
    bit         m_irq = 1'b0;

    vector_irq_ctrl #(.NCH(NCH), .SPUR_VEC(9'o000)) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .dev_irq (dev_irq),
        .dev_vec (dev_vec),
        .dev_iack(dev_iack),
        .irq_o   (irq),
        .istb_i  (istb),
        .vec_o   (vec),
        .iack_o  (iack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int  first;
        int  svc;
        bit  rise;
        logic [NCH-1:0] exp_dack;
        @(posedge clk);
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_pend[c] = 1'b0;
                m_prev[c] = 1'b0;
            end
            since  = -1;
            m_sel  = 0;
            m_spur = 1'b0;
            m_vec  = '0;
            m_irq  = 1'b0;
        end else begin
            svc   = (since == 0 && !m_spur) ? m_sel : -1;
            first = -1;
            for (int c = NCH - 1; c >= 0; c--) if (m_pend[c]) first = c;
            if (since < 0) begin
                if (istb) begin
                    since  = 0;
                    m_spur = (first < 0);
                    m_sel  = m_spur ? 0 : first;
                    m_vec  = m_spur ? 9'o000 : dev_vec[first*VW +: VW];
                end
            end else if (since < 2) since++;
            else if (!istb) begin
                since = -1;
                m_vec = '0;
            end
            m_irq = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                rise      = dev_irq[c] && !m_prev[c];
                m_pend[c] = rise || (m_pend[c] && dev_irq[c] && c != svc);
                m_prev[c] = dev_irq[c];
                m_irq     = m_irq | m_pend[c];
            end
        end
        #1;
        exp_dack = (since == 1 && !m_spur) ? NCH'(1) << m_sel : '0;
        check("irq_o", 32'(irq), 32'(m_irq));
        check("vec_o", 32'(vec), 32'(m_vec));
        check("iack_o", 32'(iack), 32'(since == 1));
        check("dev_iack", 32'(dev_iack), 32'(exp_dack));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int pulses;
        dev_vec = {9'o070, 9'o060, 9'o064, 9'o050};
        // reset
        steps(2);
        check("rst_irq", 32'(irq), 0);
        check("rst_vec", 32'(vec), 0);
        check("rst_iack", 32'(iack), 0);
        rst = 1'b0;
        step();
        // single request on ch2
        dev_irq[2] = 1'b1;
        step();
        check("single_irq", 32'(irq), 1);
        step();
        istb = 1'b1;
        step();
        check("single_vec", 32'(vec), 32'(9'o060));
        check("single_noack_yet", 32'(iack), 0);
        step();
        check("single_iack", 32'(iack), 1);
        check("single_dev_iack", 32'(dev_iack), 32'h4);
        check("single_irq_drop", 32'(irq), 0);
        step();
        check("single_iack_once", 32'(iack), 0);
        steps(2);
        istb = 1'b0;
        step();
        check("single_vec_clear", 32'(vec), 0);
        dev_irq = '0;
        steps(2);
        // priority: ch1 and ch3 together
        dev_irq = 4'b1010;
        step();
        istb = 1'b1;
        step();
        check("prio_vec1", 32'(vec), 32'(9'o064));
        step();
        check("prio_dack1", 32'(dev_iack), 32'h2);
        check("prio_irq_held", 32'(irq), 1);
        steps(2);
        istb = 1'b0;
        steps(2);
        istb = 1'b1;
        step();
        check("prio_vec3", 32'(vec), 32'(9'o070));
        step();
        check("prio_dack3", 32'(dev_iack), 32'h8);
        check("prio_irq_drop", 32'(irq), 0);
        steps(2);
        istb = 1'b0;
        dev_irq = '0;
        steps(2);
        // withdrawal then spurious strobe
        dev_irq[0] = 1'b1;
        step();
        dev_irq[0] = 1'b0;
        step();
        check("withdraw_irq", 32'(irq), 0);
        istb = 1'b1;
        step();
        check("spur_vec", 32'(vec), 0);
        step();
        check("spur_iack", 32'(iack), 1);
        check("spur_dack", 32'(dev_iack), 0);
        steps(2);
        istb = 1'b0;
        steps(2);
        // set-wins: ch2 re-rises in the LATCH cycle that services it
        dev_irq[2] = 1'b1;
        steps(2);
        istb = 1'b1;
        dev_irq[2] = 1'b0;
        step();
        dev_irq[2] = 1'b1;
        step();
        check("setwin_dack", 32'(dev_iack), 32'h4);
        check("setwin_irq", 32'(irq), 1);
        steps(2);
        istb = 1'b0;
        steps(2);
        istb = 1'b1;
        steps(4);
        istb = 1'b0;
        dev_irq = '0;
        steps(2);
        // reset during LATCH
        dev_irq[1] = 1'b1;
        step();
        istb = 1'b1;
        step();
        rst = 1'b1;
        step();
        check("rstmid_iack", 32'(iack), 0);
        check("rstmid_vec", 32'(vec), 0);
        check("rstmid_irq", 32'(irq), 0);
        check("rstmid_dack", 32'(dev_iack), 0);
        rst = 1'b0;
        istb = 1'b0;
        dev_irq = '0;
        steps(3);
        // held strobe: a late ch1 waits for a fresh strobe
        dev_irq[3] = 1'b1;
        step();
        istb = 1'b1;
        step();
        dev_irq[1] = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            pulses += int'(iack);
        end
        check("held_one_ack", 32'(pulses), 1);
        check("held_ch1_pending", 32'(irq), 1);
        istb = 1'b0;
        steps(2);
        istb = 1'b1;
        step();
        check("held_vec1", 32'(vec), 32'(9'o064));
        steps(3);
        istb = 1'b0;
        dev_irq = '0;
        steps(2);
        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) dev_irq[$urandom_range(0, NCH - 1)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) istb = ~istb;
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 31) == 0) dev_vec = {$urandom, $urandom};
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
